skewed_input_buffer: RTL

Multi-lane input FIFO that feeds the west edge of the systolic array, storing whole input vectors and emitting each vector as a diagonal wavefront. Lane k leaves the buffer k cycles after lane 0. It generalises the single-lane input buffer with:
- parametrised lane count;
- full/empty/count status;
- legal simultaneous read and write;
- registered output with zero-injection when idle;
- sticky overflow and underflow error flags.

---
 rtl/skewed_input_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/skewed_input_buffer.sv
// rtl/skewed_input_buffer.sv - multi-lane vector FIFO feeding the array west edge as a diagonal wavefront
// Optional feature macro: INBUF_SKEW_EN (lane k delayed k extra cycles); undefined, all lanes emerge together.
module skewed_input_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int LANES      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr,
  input  logic [LANES*DATA_WIDTH-1:0]   i_wr_data,
  input  logic                          i_rd,
  output logic [LANES*DATA_WIDTH-1:0]   o_data,
  output logic [LANES-1:0]              o_valid,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [ADDR_WIDTH:0]           o_count,
  output logic                          o_ovf,
  output logic                          o_udf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int VW    = LANES * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [VW-1:0]         mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty, rd_acc, wr_acc;
  logic [VW-1:0]         rd_vec;

  // A full buffer still takes a push when a pop frees a slot in the same cycle.
  always_comb begin
    full     = (count_q == CNT_FULL);
    empty    = (count_q == '0);
    rd_acc   = i_rd && !empty;
    wr_acc   = i_wr && (!full || rd_acc);
    rd_vec   = mem_q[rd_ptr_q];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q || (i_wr && !wr_acc);
    udf_d    = udf_q || (i_rd && !rd_acc);
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc) mem_q[wr_ptr_q] <= i_wr_data;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef INBUF_SKEW_EN
    localparam int STAGES = k + 1;
`else
    localparam int STAGES = 1;
`endif
    logic [DATA_WIDTH-1:0] dat_q [STAGES];
    logic [DATA_WIDTH-1:0] dat_d [STAGES];
    logic [STAGES-1:0]     vld_q, vld_d;

    // Zeros enter the line whenever no pop is accepted, so idle slots carry zero data.
    always_comb begin
      dat_d[0] = rd_acc ? rd_vec[k*DATA_WIDTH +: DATA_WIDTH] : '0;
      vld_d    = '0;
      vld_d[0] = rd_acc;
      for (int j = 1; j < STAGES; j++) begin
        dat_d[j] = dat_q[j-1];
        vld_d[j] = vld_q[j-1];
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        vld_q <= '0;
        for (int j = 0; j < STAGES; j++) dat_q[j] <= '0;
      end else begin
        vld_q <= vld_d;
        for (int j = 0; j < STAGES; j++) dat_q[j] <= dat_d[j];
      end
    end

    assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = dat_q[STAGES-1];
    assign o_valid[k]                         = vld_q[STAGES-1];
  end

  assign o_full  = full;
  assign o_empty = empty;
  assign o_count = count_q;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;

endmodule
